// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Build option: REGFILE_SB_FLUSH_EN adds a scoreboard flush input.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int PEND_W_DEF = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  typedef logic [PEND_W_DEF-1:0] pend_t;

  function automatic int aw_of(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One pending-write counter for a single architectural register.
// Saturating up/down; flush clears it; a decrement at zero is dropped.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         flush,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CMAX = '1;

  logic dec_ok;
  logic inc_ok;

  assign dec_ok = dec && (count != '0);
  assign inc_ok = inc && (count != CMAX);

  // a decrement and an increment landing together cancel out
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (inc && !dec_ok) begin
      if (inc_ok) count <= count + 1'b1;
    end else if (dec_ok && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a
// pending-write scoreboard. Build option: REGFILE_SB_FLUSH_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = aw_of(NREGS),
  parameter int NRD    = 2,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
`ifdef REGFILE_SB_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [NRD*AW-1:0] src_id_i,
  input  logic [NRD-1:0]    src_en_i,
  input  logic              dst_en_i,
  input  logic [AW-1:0]     dst_id_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_id_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              busy_o
);

  localparam logic [AW-1:0]     RZ    = AW'(REG_ZERO);
  localparam logic [PEND_W-1:0] P_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] P_MAX = '1;

  logic [XLEN-1:0]   regs [NREGS];
  logic [PEND_W-1:0] pend [NREGS];

  logic flush;
  logic fire;
  logic src_haz;
  logic dst_haz;
  logic [AW-1:0] sid;
  logic [AW-1:0] rid;

`ifdef REGFILE_SB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign pend[0] = '0;

  genvar r;
  generate
    for (r = 1; r < NREGS; r++) begin : g_cnt
      sb_counter #(.W(PEND_W)) u_cnt (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .inc     (fire && dst_en_i && dst_id_i == AW'(r)),
        .dec     (wb_en_i && wb_id_i == AW'(r)),
        .flush   (flush),
        .count   (pend[r])
      );
    end
  endgenerate

  // architectural state; x0 is never written
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en_i && wb_id_i != RZ) begin
      regs[wb_id_i] <= wb_data_i;
    end
  end

  // read ports with same-cycle writeback bypass
  always_comb begin
    rd_data_o = '0;
    rid = '0;
    for (int k = 0; k < NRD; k++) begin
      rid = src_id_i[k*AW +: AW];
      if (rid == RZ)
        rd_data_o[k*XLEN +: XLEN] = '0;
      else if (wb_en_i && wb_id_i == rid)
        rd_data_o[k*XLEN +: XLEN] = wb_data_i;
      else
        rd_data_o[k*XLEN +: XLEN] = regs[rid];
    end
  end

  // RAW check; the last outstanding write arriving now is not a hazard
  always_comb begin
    src_haz = 1'b0;
    sid = '0;
    for (int k = 0; k < NRD; k++) begin
      sid = src_id_i[k*AW +: AW];
      if (src_en_i[k] && sid != RZ && pend[sid] != '0 &&
          !(pend[sid] == P_ONE && wb_en_i && wb_id_i == sid))
        src_haz = 1'b1;
    end
  end

  // WAW check: stall only when the destination counter is saturated
  always_comb begin
    dst_haz = dst_en_i && dst_id_i != RZ &&
              pend[dst_id_i] == P_MAX &&
              !(wb_en_i && wb_id_i == dst_id_i);
  end

  assign issue_ready_o = !src_haz && !dst_haz && !flush;
  assign fire = issue_valid_i && issue_ready_o;

  // busy whenever any register has a write in flight
  always_comb begin
    busy_o = 1'b0;
    for (int i = 1; i < NREGS; i++)
      busy_o = busy_o | (pend[i] != '0);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised bench for regfile_scoreboard against an array/counter
// model of the register file and its pending-write bookkeeping.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int PMAX = 3;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic issue_valid_i;
  logic issue_ready_o;
  logic [NRD*AW-1:0] src_id_i;
  logic [NRD-1:0] src_en_i;
  logic dst_en_i;
  logic [AW-1:0] dst_id_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic wb_en_i;
  logic [AW-1:0] wb_id_i;
  logic [XLEN-1:0] wb_data_i;
  logic busy_o;
`ifdef REGFILE_SB_FLUSH_EN
  logic flush_i;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int mpend [NREGS];
  logic [XLEN-1:0] mreg [NREGS];

  regfile_scoreboard dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
`ifdef REGFILE_SB_FLUSH_EN
    .flush_i       (flush_i),
`endif
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .src_id_i      (src_id_i),
    .src_en_i      (src_en_i),
    .dst_en_i      (dst_en_i),
    .dst_id_i      (dst_id_i),
    .rd_data_o     (rd_data_o),
    .wb_en_i       (wb_en_i),
    .wb_id_i       (wb_id_i),
    .wb_data_i     (wb_data_i),
    .busy_o        (busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic m_flush();
`ifdef REGFILE_SB_FLUSH_EN
    return flush_i;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [XLEN-1:0] m_rd(input int k);
    int id;
    id = int'(src_id_i[k*AW +: AW]);
    if (id == 0) return '0;
    if (wb_en_i && int'(wb_id_i) == id) return wb_data_i;
    return mreg[id];
  endfunction

  function automatic logic m_ready();
    int id;
    int d;
    int w;
    if (m_flush()) return 1'b0;
    w = wb_en_i ? int'(wb_id_i) : -1;
    for (int k = 0; k < NRD; k++) begin
      id = int'(src_id_i[k*AW +: AW]);
      if (src_en_i[k] && id != 0 && mpend[id] > 0 &&
          !(mpend[id] == 1 && w == id))
        return 1'b0;
    end
    d = int'(dst_id_i);
    if (dst_en_i && d != 0 && mpend[d] == PMAX && w != d)
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    for (int i = 0; i < NREGS; i++)
      if (mpend[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ready", 32'(issue_ready_o), 32'(m_ready()));
    chk("busy", 32'(busy_o), 32'(m_busy()));
    for (int k = 0; k < NRD; k++)
      chk($sformatf("rd%0d", k), rd_data_o[k*XLEN +: XLEN], m_rd(k));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mpend[i] = 0;
      mreg[i] = '0;
    end
  endtask

  task automatic model_step();
    logic fire;
    int w;
    int d;
    fire = issue_valid_i && m_ready();
    w = int'(wb_id_i);
    d = int'(dst_id_i);
    if (m_flush()) begin
      for (int i = 0; i < NREGS; i++) mpend[i] = 0;
    end else begin
      if (wb_en_i && w != 0 && mpend[w] > 0) mpend[w]--;
      if (fire && dst_en_i && d != 0) mpend[d]++;
      if (mpend[d] > PMAX) begin
        n_bad++;
        $display("FAIL model_sat: pend[%0d]=%0d", d, mpend[d]);
      end
    end
    if (wb_en_i && w != 0) mreg[w] = wb_data_i;
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic drive(input logic v, input int s0, input int s1,
                       input logic [1:0] sen, input logic den,
                       input int did, input logic wen, input int wid,
                       input logic [XLEN-1:0] wd);
    issue_valid_i = v;
    src_id_i = {AW'(s1), AW'(s0)};
    src_en_i = sen;
    dst_en_i = den;
    dst_id_i = AW'(did);
    wb_en_i = wen;
    wb_id_i = AW'(wid);
    wb_data_i = wd;
`ifdef REGFILE_SB_FLUSH_EN
    flush_i = 1'b0;
`endif
  endtask

  function automatic int pick_id();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, NREGS-1));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic drive_random();
    int cand [$];
    int wid;
    drive($urandom_range(0, 3) != 0, pick_id(), pick_id(),
          2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          pick_id(), 1'b0, 0, '0);
    for (int i = 1; i < NREGS; i++)
      if (mpend[i] > 0) cand.push_back(i);
    wid = pick_id();
    if (cand.size() > 0 && $urandom_range(0, 9) < 7)
      wid = cand[$urandom_range(0, cand.size()-1)];
    wb_en_i = $urandom_range(0, 1) == 1;
    wb_id_i = AW'(wid);
    wb_data_i = $urandom;
`ifdef REGFILE_SB_FLUSH_EN
    flush_i = $urandom_range(0, 29) == 0;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 5, 7, 2'b11, 0, 0, 0, 0, '0);
    model_clear();
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;

    // reset state
    #1;
    chk("rst_rd0", rd_data_o[0 +: XLEN], 32'h0);
    chk("rst_rd1", rd_data_o[XLEN +: XLEN], 32'h0);
    chk("rst_ready", 32'(issue_ready_o), 32'h1);
    chk("rst_busy", 32'(busy_o), 32'h0);
    cycle();

    // RAW stall on x5, released by its writeback with bypass
    drive(1, 0, 0, 2'b00, 1, 5, 0, 0, '0);
    cycle();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, '0);
    #1 chk("raw_stall", 32'(issue_ready_o), 32'h0);
    cycle();
    drive(1, 5, 0, 2'b01, 0, 0, 1, 5, 32'hDEADBEEF);
    #1 chk("raw_release", 32'(issue_ready_o), 32'h1);
    chk("raw_bypass", rd_data_o[0 +: XLEN], 32'hDEADBEEF);
    cycle();
    drive(0, 5, 0, 2'b01, 0, 0, 0, 0, '0);
    #1 chk("raw_busy_clr", 32'(busy_o), 32'h0);
    chk("raw_reg5", rd_data_o[0 +: XLEN], 32'hDEADBEEF);
    cycle();

    // WAW saturation on x9
    repeat (3) begin
      drive(1, 0, 0, 2'b00, 1, 9, 0, 0, '0);
      cycle();
    end
    chk("sat_model", 32'(mpend[9]), 32'd3);
    drive(1, 0, 0, 2'b00, 1, 9, 0, 0, '0);
    #1 chk("sat_stall", 32'(issue_ready_o), 32'h0);
    cycle();
    drive(1, 0, 0, 2'b00, 1, 9, 1, 9, 32'h99);
    #1 chk("sat_wb_fire", 32'(issue_ready_o), 32'h1);
    cycle();
    chk("sat_hold", 32'(mpend[9]), 32'd3);
    #1 chk("sat_busy", 32'(busy_o), 32'h1);
    repeat (3) begin
      drive(0, 0, 0, 2'b00, 0, 0, 1, 9, 32'h99);
      cycle();
    end

    // fire and writeback to x3 together keep it pending
    drive(1, 0, 0, 2'b00, 1, 3, 0, 0, '0);
    cycle();
    drive(1, 0, 0, 2'b00, 1, 3, 1, 3, 32'h33);
    cycle();
    drive(1, 3, 0, 2'b01, 0, 0, 0, 0, '0);
    #1 chk("inc_dec_stall", 32'(issue_ready_o), 32'h0);
    chk("inc_dec_data", rd_data_o[0 +: XLEN], 32'h33);
    cycle();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 3, 32'h44);
    cycle();

    // x0 is inert; stray writeback still writes data
    drive(1, 0, 0, 2'b11, 1, 0, 1, 0, 32'h1234);
    #1 chk("x0_rd", rd_data_o[0 +: XLEN], 32'h0);
    cycle();
    drive(0, 0, 0, 2'b11, 0, 0, 1, 4, 32'hCAFE);
    #1 chk("x0_busy", 32'(busy_o), 32'h0);
    cycle();
    drive(1, 4, 0, 2'b01, 0, 0, 0, 0, '0);
    #1 chk("stray_data", rd_data_o[0 +: XLEN], 32'hCAFE);
    chk("stray_ready", 32'(issue_ready_o), 32'h1);
    cycle();

`ifdef REGFILE_SB_FLUSH_EN
    drive(1, 0, 0, 2'b00, 0, 0, 1, 6, 32'h66);
    cycle();
    repeat (2) begin
      drive(1, 0, 0, 2'b00, 1, 6, 0, 0, '0);
      cycle();
    end
    drive(1, 0, 0, 2'b00, 1, 6, 0, 0, '0);
    flush_i = 1'b1;
    #1 chk("flush_ready", 32'(issue_ready_o), 32'h0);
    cycle();
    drive(1, 6, 0, 2'b01, 0, 0, 0, 0, '0);
    #1 chk("flush_busy", 32'(busy_o), 32'h0);
    chk("flush_data", rd_data_o[0 +: XLEN], 32'h66);
    chk("flush_ready2", 32'(issue_ready_o), 32'h1);
    cycle();
`endif

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, '0);
        rst_n = 1'b0;
        model_clear();
        #1 chk("midrst_busy", 32'(busy_o), 32'h0);
        chk("midrst_ready", 32'(issue_ready_o), 32'h1);
        #1 rst_n = 1'b1;
      end
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
